// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM address,
// registers {instr, pc, valid} into the IF/ID stage with a ready/valid stall
// toward decode, takes branch redirects and halts in a sticky fault state on
// an illegal fetch target.
//
// Build option: define FETCH_BOUNDS_CHECK_EN to treat addresses whose last
// byte falls outside IMEM_BYTES as illegal. Without it only misaligned
// addresses are illegal and the ROM address wraps modulo IMEM_BYTES.
module instr_fetch_unit #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] ADDR_MASK  = XLEN'(IMEM_BYTES - 1);
    localparam logic [XLEN-1:0] LAST_WORD  = XLEN'(IMEM_BYTES - 4);
    localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(4);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic              valid_d;
    logic [ILEN-1:0]   instr_d;
    logic [XLEN-1:0]   if_pc_d;
    logic              fault_d;
    logic [XLEN-1:0]   fault_pc_d;
    logic [XLEN-1:0]   pc_next_seq;
    logic              advance;

    // An address is illegal when misaligned or, with bounds checking, when
    // any byte of the word lies at or beyond IMEM_BYTES.
    function automatic logic is_illegal(input logic [XLEN-1:0] addr);
        logic misaligned;
        logic past_end;
        misaligned = (addr[1:0] != 2'b00);
        past_end   = (addr > LAST_WORD);
        return misaligned || (BOUNDS_EN && past_end);
    endfunction

    assign advance     = !if_valid || id_ready;
    assign pc_next_seq = pc + INSTR_STEP;

    // ROM address follows the PC; it is masked into the ROM when unbounded.
    always_comb begin
        if (BOUNDS_EN) begin
            imem_address = pc;
        end else begin
            imem_address = pc & ADDR_MASK;
        end
    end

    // State and IF/ID register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            if_valid <= valid_d;
            if_instr <= instr_d;
            if_pc    <= if_pc_d;
            fault    <= fault_d;
            fault_pc <= fault_pc_d;
        end
    end

    // Next-state and next IF/ID contents; redirect beats stall, stall holds all.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        valid_d    = if_valid;
        instr_d    = if_instr;
        if_pc_d    = if_pc;
        fault_d    = fault;
        fault_pc_d = fault_pc;

        unique case (state)
            ST_RUN: begin
                if (br_taken) begin
                    valid_d = 1'b0;
                    if (is_illegal(br_target)) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = br_target;
                    end else begin
                        pc_d = br_target;
                    end
                end else if (advance) begin
                    instr_d = imem_instruction;
                    if_pc_d = pc;
                    valid_d = 1'b1;
                    if (is_illegal(pc_next_seq)) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_next_seq;
                    end else begin
                        pc_d = pc_next_seq;
                    end
                end
            end
            ST_FAULT: begin
                // Let decode drain the last valid word, then go quiet.
                if (if_valid && id_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random redirects,
// stalls and resets, all compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int unsigned IMEM_BYTES = 1024;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam int unsigned ROM_WORDS  = IMEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        fault;
    logic [63:0] fault_pc;

    logic [31:0] rom [ROM_WORDS];

    // Reference model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;
    logic        m_fault;
    logic [63:0] m_fault_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_instruction = rom[imem_address[9:2]];

    instr_fetch_unit #(
        .IMEM_BYTES(IMEM_BYTES),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_illegal(input logic [63:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
        return (a % 4 != 0) || ({1'b0, a} + 65'd3 >= 65'(IMEM_BYTES));
`else
        return (a % 4 != 0);
`endif
    endfunction

    function automatic logic [63:0] m_addr();
`ifdef FETCH_BOUNDS_CHECK_EN
        return m_pc;
`else
        return m_pc % 64'(IMEM_BYTES);
`endif
    endfunction

    // One clock edge of the fetch unit as described by its behavioural rules.
    task automatic model_step();
        logic [63:0] a;
        logic [63:0] nxt;
        if (reset) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
            m_fault = 1'b0; m_fault_pc = '0;
            return;
        end
        if (m_fault) begin
            if (m_valid && id_ready) m_valid = 1'b0;
            return;
        end
        if (br_taken) begin
            m_valid = 1'b0;
            if (m_illegal(br_target)) begin
                m_fault = 1'b1; m_fault_pc = br_target;
            end else begin
                m_pc = br_target;
            end
            return;
        end
        if (!m_valid || id_ready) begin
            a       = m_addr();
            m_instr = rom[a / 4];
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            nxt     = m_pc + 64'd4;
            if (m_illegal(nxt)) begin
                m_fault = 1'b1; m_fault_pc = nxt;
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    // Advance one clock, update the model at the edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("if_valid", 64'(if_valid), 64'(m_valid));
        chk("if_instr", 64'(if_instr), 64'(m_instr));
        chk("if_pc", if_pc, m_ifpc);
        chk("fault", 64'(fault), 64'(m_fault));
        chk("fault_pc", fault_pc, m_fault_pc);
        chk("imem_address", imem_address, m_addr());
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(0, 9))
            0:       t = 64'(4 * $urandom_range(0, ROM_WORDS - 1) + $urandom_range(1, 3));
            1:       t = 64'(IMEM_BYTES - 32 + 4 * $urandom_range(0, 7));
            2:       t = 64'h1_0000_0000 + 64'(4 * $urandom_range(0, ROM_WORDS - 1));
            default: t = 64'(4 * $urandom_range(0, ROM_WORDS - 1));
        endcase
        return t;
    endfunction

    initial begin
        for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
        rom[0] = 32'hA000_000A;
        rom[1] = 32'hB000_000B;
        rom[2] = 32'hC000_000C;
        reset = 1'b1; br_taken = 1'b0; br_target = '0; id_ready = 1'b1;
        m_pc = RESET_PC; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
        m_fault = 1'b0; m_fault_pc = '0;

        // Reset for two cycles, then sequential fetch of A, B, C
        cycle(); cycle();
        chk("rst_valid", 64'(if_valid), 64'd0);
        chk("rst_addr", imem_address, 64'd0);
        reset = 1'b0;
        cycle();
        chk("t1_pc0", if_pc, 64'd0);
        chk("t1_A", 64'(if_instr), 64'hA000_000A);
        chk("t1_v0", 64'(if_valid), 64'd1);
        cycle();
        chk("t1_pc4", if_pc, 64'd4);
        chk("t1_B", 64'(if_instr), 64'hB000_000B);

        // Stall three cycles holding B
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_hold_pc", if_pc, 64'd4);
            chk("t2_hold_instr", 64'(if_instr), 64'hB000_000B);
            chk("t2_addr", imem_address, 64'd8);
        end
        id_ready = 1'b1;
        cycle();
        chk("t2_pc8", if_pc, 64'd8);
        chk("t2_C", 64'(if_instr), 64'hC000_000C);

        // Redirect while stalled: one bubble, then the target
        id_ready = 1'b0; br_taken = 1'b1; br_target = 64'h40;
        cycle();
        chk("t3_bubble", 64'(if_valid), 64'd0);
        chk("t3_addr", imem_address, 64'h40);
        br_taken = 1'b0; id_ready = 1'b1;
        cycle();
        chk("t3_pc", if_pc, 64'h40);
        chk("t3_instr", 64'(if_instr), 64'(rom[16]));

        // Misaligned redirect faults; later redirects are ignored
        br_taken = 1'b1; br_target = 64'h42;
        cycle();
        chk("t4_fault", 64'(fault), 64'd1);
        chk("t4_fault_pc", fault_pc, 64'h42);
        chk("t4_valid", 64'(if_valid), 64'd0);
        br_target = 64'h0;
        cycle(); cycle();
        chk("t4_sticky", 64'(fault), 64'd1);
        chk("t4_ignored", 64'(if_valid), 64'd0);

        // Reset in FAULT with concurrent redirect
        reset = 1'b1; br_target = 64'h80;
        cycle();
        chk("t6_fault", 64'(fault), 64'd0);
        chk("t6_fault_pc", fault_pc, 64'd0);
        chk("t6_addr", imem_address, RESET_PC);
        chk("t6_ifpc", if_pc, 64'd0);
        reset = 1'b0; br_taken = 1'b0;
        cycle();
        chk("t6_restart", if_pc, 64'd0);
        chk("t6_restart_A", 64'(if_instr), 64'hA000_000A);

        // End-of-memory behaviour
        br_taken = 1'b1; br_target = 64'h3F8;
        cycle();
        br_taken = 1'b0;
        cycle();
        chk("t5_3f8", if_pc, 64'h3F8);
        cycle();
        chk("t5_3fc", if_pc, 64'h3FC);
        chk("t5_instr", 64'(if_instr), 64'(rom[255]));
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("t5_fault", 64'(fault), 64'd1);
        chk("t5_fault_pc", fault_pc, 64'h400);
        cycle();
        chk("t5_drain", 64'(if_valid), 64'd0);
`else
        chk("t5_nofault", 64'(fault), 64'd0);
        chk("t5_wrap_addr", imem_address, 64'h0);
        cycle();
        chk("t5_wrap_pc", if_pc, 64'h400);
        chk("t5_wrap_instr", 64'(if_instr), 64'hA000_000A);
`endif

        // Random redirects, stalls and resets
        for (int n = 0; n < 4000; n++) begin
            reset     = (m_fault && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
            br_taken  = ($urandom_range(0, 7) == 0);
            br_target = rand_target();
            id_ready  = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
